// File: rtl/conc_serializer.sv
// conc_serializer: buffers up to two five-word result frames (a..e) and
// streams each one as five consecutive tagged words on a single output.
module conc_serializer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] e,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [2:0]       out_idx,
  output logic             out_last,
  output logic [15:0]      frames_done
);

  // Word k of a frame lives in slice [k], so word 0 is a and word 4 is e.
  typedef logic [4:0][WIDTH-1:0] frame_t;

  localparam logic [2:0] LAST_IDX = 3'd4;

  frame_t      frame_buf [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  cnt;
  logic [2:0]  idx;
  logic [15:0] done_cnt;

  logic        push;
  logic        xfer;
  logic        pop;
  frame_t      head;

  // NOTE: the handshake flags come from registered state only, so neither
  // in_valid nor out_ready can form a combinational path to a ready/valid.
  assign in_ready  = (cnt != 2'd2);
  assign out_valid = (cnt != 2'd0);

  assign push = in_valid && in_ready;
  assign xfer = out_valid && out_ready;
  assign pop  = xfer && (idx == LAST_IDX);

  assign head        = frame_buf[rd_ptr];
  assign out_idx     = idx;
  assign out_last    = out_valid && (idx == LAST_IDX);
  assign frames_done = done_cnt;

  // Select the current word of the head frame; an empty buffer reads zero.
  always_comb begin
    out_data = '0;
    if (out_valid) begin
      case (idx)
        3'd0:    out_data = head[0];
        3'd1:    out_data = head[1];
        3'd2:    out_data = head[2];
        3'd3:    out_data = head[3];
        default: out_data = head[4];
      endcase
    end
  end

  // Frame storage: write the accepted frame into the slot at wr_ptr.
  // NOTE: the data array is deliberately not reset; cnt gates every read,
  // so stale contents can never reach out_data after a reset.
  always_ff @(posedge clk) begin
    if (push) begin
      frame_buf[wr_ptr] <= {e, d, c, b, a};
    end
  end

  // Control state: pointers, occupancy, word index and completed-frame count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      cnt      <= 2'd0;
      idx      <= 3'd0;
      done_cnt <= 16'd0;
    end else begin
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end

      if (xfer) begin
        if (idx == LAST_IDX) begin
          idx      <= 3'd0;
          rd_ptr   <= ~rd_ptr;
          done_cnt <= done_cnt + 16'd1;
        end else begin
          idx <= idx + 3'd1;
        end
      end

      // A simultaneous push and pop leaves the occupancy unchanged.
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_conc_serializer.sv
// Self-checking bench for conc_serializer: a queue-of-frames reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_conc_serializer;

  typedef logic [4:0][31:0] frame_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b, c, d, e;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [2:0]  out_idx;
  logic        out_last;
  logic [15:0] frames_done;

  int errors = 0;
  int checks = 0;

  conc_serializer #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .c           (c),
    .d           (d),
    .e           (e),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_idx     (out_idx),
    .out_last    (out_last),
    .frames_done (frames_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  frame_t      fq[$];
  int          widx    = 0;
  int          md_done = 0;
  int          offset  = 0;
  bit          chk_en  = 1'b0;

  // Advance the model on each rising edge from the inputs present at that edge.
  always @(posedge clk) begin
    if (rst) begin
      fq.delete();
      widx    = 0;
      md_done = 0;
    end else begin
      bit do_push;
      bit do_xfer;
      do_push = in_valid && (fq.size() < 2);
      do_xfer = (fq.size() > 0) && out_ready;
      if (do_xfer) begin
        if (widx == 4) begin
          void'(fq.pop_front());
          widx    = 0;
          md_done = (md_done + 1) % 65536;
        end else begin
          widx++;
        end
      end
      if (do_push) fq.push_back({e, d, c, b, a});
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      int          sz;
      logic [31:0] exp_data;
      sz       = fq.size();
      exp_data = (sz > 0) ? fq[0][widx] : 32'd0;
      check("m_in_ready",  {31'd0, in_ready},    {31'd0, sz < 2});
      check("m_out_valid", {31'd0, out_valid},   {31'd0, sz > 0});
      check("m_out_data",  out_data,             exp_data);
      check("m_out_idx",   {29'd0, out_idx},     widx);
      check("m_out_last",  {31'd0, out_last},    {31'd0, (sz > 0) && (widx == 4)});
      check("m_frames",    {16'd0, frames_done}, (md_done + offset) % 65536);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic frame_t mk(input logic [31:0] w0, w1, w2, w3, w4);
    return {w4, w3, w2, w1, w0};
  endfunction

  task automatic drive(input frame_t f);
    in_valid = 1'b1;
    a = f[0]; b = f[1]; c = f[2]; d = f[3]; e = f[4];
  endtask

  // Expect words first..first+n-1 of f on consecutive cycles with out_ready high.
  task automatic stream_check(input string tag, input frame_t f, input int first, input int n);
    for (int k = first; k < first + n; k++) begin
      @(negedge clk);
      check({tag, "_data"}, out_data, f[k]);
      check({tag, "_idx"},  {29'd0, out_idx}, k);
      check({tag, "_last"}, {31'd0, out_last}, {31'd0, k == 4});
      tick();
    end
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (12) tick();
  endtask

  frame_t f_single, f_a, f_b, f_c, f_p, f_q, f_r1, f_r2, f_r3;

  initial begin
    f_single = mk(32'd15, 32'd45, 32'd60, 32'd9, 32'd25);
    f_a  = mk(32'd1,   32'd2,   32'd3,   32'd4,   32'd5);
    f_b  = mk(32'd11,  32'd12,  32'd13,  32'd14,  32'd15);
    f_c  = mk(32'd21,  32'd22,  32'd23,  32'd24,  32'd25);
    f_p  = mk(32'd101, 32'd102, 32'd103, 32'd104, 32'd105);
    f_q  = mk(32'd201, 32'd202, 32'd203, 32'd204, 32'd205);
    f_r1 = mk(32'd31,  32'd32,  32'd33,  32'd34,  32'd35);
    f_r2 = mk(32'd41,  32'd42,  32'd43,  32'd44,  32'd45);
    f_r3 = mk(32'd51,  32'd52,  32'd53,  32'd54,  32'd55);

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; c = '0; d = '0; e = '0;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;

    // Reset values.
    @(negedge clk);
    check("rst_in_ready",  {31'd0, in_ready},    32'd1);
    check("rst_out_valid", {31'd0, out_valid},   32'd0);
    check("rst_out_data",  out_data,             32'd0);
    check("rst_out_idx",   {29'd0, out_idx},     32'd0);
    check("rst_out_last",  {31'd0, out_last},    32'd0);
    check("rst_frames",    {16'd0, frames_done}, 32'd0);

    // Single frame, 1-cycle latency, five consecutive words.
    tick();
    out_ready = 1'b1;
    drive(f_single);
    tick();
    in_valid = 1'b0;
    stream_check("single", f_single, 0, 5);
    @(negedge clk);
    check("single_frames", {16'd0, frames_done}, 32'd1);
    check("single_empty",  {31'd0, out_valid},   32'd0);

    // Fill and block: third frame must be refused.
    tick();
    out_ready = 1'b0;
    drive(f_a);
    tick();
    drive(f_b);
    tick();
    @(negedge clk);
    check("fill_in_ready", {31'd0, in_ready}, 32'd0);
    drive(f_c);
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("fill_data",     out_data, (k < 5) ? f_a[k] : f_b[k - 5]);
      check("fill_in_ready", {31'd0, in_ready}, {31'd0, k >= 5});
      tick();
    end
    @(negedge clk);
    check("fill_third_dropped", {31'd0, out_valid}, 32'd0);
    check("fill_frames",        {16'd0, frames_done}, 32'd3);

    // Stall mid-frame at word 2.
    tick();
    drive(f_single);
    tick();
    in_valid = 1'b0;
    stream_check("stall_pre", f_single, 0, 2);
    out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("stall_data", out_data, 32'd60);
      check("stall_idx",  {29'd0, out_idx}, 32'd2);
      check("stall_last", {31'd0, out_last}, 32'd0);
      tick();
    end
    out_ready = 1'b1;
    stream_check("stall_post", f_single, 2, 3);

    // Push coinciding with the pop of the last word: no bubble.
    drive(f_p);
    tick();
    in_valid = 1'b0;
    stream_check("pp_first", f_p, 0, 4);
    drive(f_q);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("pp_valid",    {31'd0, out_valid}, 32'd1);
    check("pp_data",     out_data, 32'd201);
    check("pp_idx",      {29'd0, out_idx}, 32'd0);
    check("pp_in_ready", {31'd0, in_ready}, 32'd1);
    drain();

    // Reset mid-operation with two frames buffered at word 3.
    out_ready = 1'b0;
    drive(f_r1);
    tick();
    drive(f_r2);
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("mid_idx", {29'd0, out_idx}, 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("mid_out_valid", {31'd0, out_valid},   32'd0);
    check("mid_in_ready",  {31'd0, in_ready},    32'd1);
    check("mid_frames",    {16'd0, frames_done}, 32'd0);
    drive(f_r3);
    tick();
    in_valid = 1'b0;
    stream_check("mid_after", f_r3, 0, 5);
    @(negedge clk);
    check("mid_no_stale", {31'd0, out_valid}, 32'd0);

    // Randomised traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      in_valid  = ($urandom_range(0, 9) < 6);
      out_ready = ($urandom_range(0, 9) < 7);
      a = $urandom(); b = $urandom(); c = $urandom(); d = $urandom(); e = $urandom();
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;
    drain();

    // Counter wrap: preload near the limit instead of streaming 65536 frames.
    out_ready = 1'b0;
    tick();
    offset = (65534 - md_done + 65536) % 65536;
    force dut.done_cnt = 16'hFFFE;
    tick();
    release dut.done_cnt;
    tick();
    out_ready = 1'b1;
    drive(f_a);
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    @(negedge clk);
    check("wrap_fffe_plus1", {16'd0, frames_done}, 32'd65535);
    drive(f_b);
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    @(negedge clk);
    check("wrap_to_zero", {16'd0, frames_done}, 32'd0);

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global bound so the bench always terminates.
  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: got running expected finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
